bullet_controller: RTL and testbench
====================================

BULLET_CONTROLLER -- requirements
Module: bullet_controller

Interface
REQ-001 Parameter SCREEN_X_MAX, default 639, meaning rightmost valid pixel column.
REQ-002 Parameter SCREEN_Y_MAX, default 479, meaning bottom valid pixel row.
REQ-003 Parameter BULLET_STEP, default 4, meaning pixels moved per frame tick.
REQ-004 Parameter BULLET_SIZE, default 2, meaning bullet half-size driven on Bullet_Size.
REQ-005 Parameter COOLDOWN_FRAMES, default 8, meaning frame ticks spent in COOLDOWN; legal range 1..255.
REQ-006 Port Clk, input, 1, meaning the single system clock.
REQ-007 Port Reset_n, input, 1, meaning synchronous active-low reset.
REQ-008 Port frame_clk, input, 1, meaning frame strobe; asynchronous to Clk.
REQ-009 Port fire, input, 1, meaning shoot request.
REQ-010 Port direction, input, 2, meaning 00 up, 01 down, 10 left, 11 right.
REQ-011 Port BallX/BallY, input, 10 each, meaning player centre and spawn origin.
REQ-012 Port bullet_collision, input, 1, meaning barrier-hit flag from the barrier block.
REQ-013 Port BulletX/BulletY, output, 10 each, meaning bullet centre.
REQ-014 Port Bullet_Size, output, 10, meaning constant BULLET_SIZE.
REQ-015 Port bullet_active, output, 1, meaning high only in FLIGHT.
REQ-016 Port shot_done, output, 1, meaning one-Clk pulse on despawn.
REQ-017 Port despawn_cause, output, 2, meaning 00 none, 01 barrier, 10 screen edge.

Function
REQ-018 frame_clk SHALL pass through a 2-flop synchronizer and a rising-edge detector, producing a one-Clk tick 3 Clk cycles after the rising edge.
REQ-019 The block SHALL implement states IDLE, FLIGHT and COOLDOWN, and SHALL evaluate all state changes and movement only on tick cycles, with registered outputs updating the cycle after the tick.
REQ-020 In IDLE on a tick with a qualified fire, the block SHALL load BulletX/Y from BallX/Y, latch direction, set despawn_cause=00 and enter FLIGHT.
REQ-021 In FLIGHT on a tick, bullet_collision=1 SHALL cause a despawn with cause 01.
REQ-022 In FLIGHT on a tick, a step that would place the centre closer than BULLET_SIZE to any screen edge SHALL cause a despawn with cause 10.
REQ-023 In FLIGHT on a tick, when neither despawn condition holds, the latched axis SHALL advance by BULLET_STEP.
REQ-024 When collision and edge conditions occur on the same tick, collision SHALL win (cause 01).
REQ-025 Edge arithmetic SHALL be computed in 11-bit unsigned so no 10-bit wrap occurs; the up condition is BulletY < BULLET_STEP+BULLET_SIZE, and the down condition is BulletY+BULLET_STEP+BULLET_SIZE > SCREEN_Y_MAX; the X axis is analogous.
REQ-026 On despawn, the block SHALL pulse shot_done for exactly one Clk, hold BulletX/Y at the last position, load the cooldown counter with COOLDOWN_FRAMES and enter COOLDOWN.
REQ-027 In COOLDOWN, the counter SHALL decrement per tick, the block SHALL return to IDLE on the tick where the counter reaches 0, and fire SHALL be ignored throughout.
REQ-028 despawn_cause SHALL hold its value until the next accepted fire.
REQ-029 direction and BallX/Y changes during FLIGHT SHALL have no effect.

Reset
REQ-030 While Reset_n=0 at a Clk edge, the block SHALL go to IDLE and clear BulletX/Y, bullet_active, shot_done, despawn_cause, the cooldown counter, the synchronizer flops and the fire history.
REQ-031 Reset asserted mid-FLIGHT or mid-COOLDOWN SHALL abort the shot without a shot_done pulse.

Configuration
REQ-032 Without BULLET_AUTOFIRE_EN, fire SHALL qualify only when sampled 1 on a tick after being sampled 0 on the previous tick, so holding fire yields one shot.
REQ-033 With BULLET_AUTOFIRE_EN defined, fire SHALL be level-qualified, so a held fire re-shoots on the first IDLE tick after each cooldown.

Structure
REQ-034 Package bullet_pkg SHALL hold the state enum, the direction enum, the despawn-cause enum and the screen-limit constants.
REQ-035 The synchronizer and edge detector SHALL be a sub-module named frame_tick_sync.

Verification
REQ-036 Ball at (160,80), direction up, fire pulse -> 19 moves ending at Y=4, then on the 20th tick despawn with cause 10, one shot_done pulse and bullet_active=0.
REQ-037 Ball at (160,240), direction right, fire, bullet_collision=1 on the 3rd flight tick -> despawn at X=168 with cause 01.
REQ-038 At Y=4 heading up with bullet_collision=1 on the same tick -> cause 01.
REQ-039 fire held high through despawn -> exactly 8 COOLDOWN ticks, then IDLE; no new shot without the macro, and a new shot on the first IDLE tick with BULLET_AUTOFIRE_EN.
REQ-040 Reset_n low for 1 Clk mid-FLIGHT -> all outputs 0, no shot_done pulse, state IDLE.
REQ-041 frame_clk rising edge -> tick exactly 3 Clk later, with no extra tick when frame_clk is held high.

Source files
------------

// File: rtl/bullet_pkg.sv
// Shared types and screen constants for the bullet controller slice.
package bullet_pkg;

    localparam int unsigned COORD_W          = 10;
    localparam int unsigned SCREEN_X_MAX_DEF = 639;
    localparam int unsigned SCREEN_Y_MAX_DEF = 479;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_FLIGHT   = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_e;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_BARRIER = 2'b01,
        CAUSE_EDGE    = 2'b10
    } cause_e;

endpackage

// File: rtl/bullet_controller_frame_tick_sync.sv
// frame_tick_sync: brings the asynchronous frame strobe into the Clk domain
// and emits a one-cycle registered tick, three Clk edges after its rising edge.
module frame_tick_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic tick_o
);

    logic meta_q;
    logic sync_q;
    logic hist_q;
    logic tick_q;

    // Two-flop synchronizer, history flop and registered rising-edge detect.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            hist_q <= sync_q;
            tick_q <= sync_q & ~hist_q;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/bullet_controller.sv
// bullet_controller: single-bullet shooter. IDLE -> FLIGHT -> COOLDOWN, all
// decisions taken on frame ticks. Optional macro BULLET_AUTOFIRE_EN makes fire
// level-qualified; by default fire needs a 0->1 transition between ticks.
module bullet_controller
    import bullet_pkg::*;
#(
    parameter int unsigned SCREEN_X_MAX    = SCREEN_X_MAX_DEF,
    parameter int unsigned SCREEN_Y_MAX    = SCREEN_Y_MAX_DEF,
    parameter int unsigned BULLET_STEP     = 4,
    parameter int unsigned BULLET_SIZE     = 2,
    parameter int unsigned COOLDOWN_FRAMES = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 frame_clk,
    input  logic                 fire,
    input  logic [1:0]           direction,
    input  logic [COORD_W-1:0]   BallX,
    input  logic [COORD_W-1:0]   BallY,
    input  logic                 bullet_collision,
    output logic [COORD_W-1:0]   BulletX,
    output logic [COORD_W-1:0]   BulletY,
    output logic [COORD_W-1:0]   Bullet_Size,
    output logic                 bullet_active,
    output logic                 shot_done,
    output logic [1:0]           despawn_cause
);

    localparam logic [10:0]        EDGE_SPAN = 11'(BULLET_STEP + BULLET_SIZE);
    localparam logic [10:0]        X_LIMIT   = 11'(SCREEN_X_MAX);
    localparam logic [10:0]        Y_LIMIT   = 11'(SCREEN_Y_MAX);
    localparam logic [COORD_W-1:0] STEP      = COORD_W'(BULLET_STEP);
    localparam logic [7:0]         CD_LOAD   = 8'(COOLDOWN_FRAMES);

    state_e              state_q;
    dir_e                dir_q;
    cause_e              cause_q;
    logic [COORD_W-1:0]  bullet_x_q;
    logic [COORD_W-1:0]  bullet_y_q;
    logic [COORD_W-1:0]  bullet_x_d;
    logic [COORD_W-1:0]  bullet_y_d;
    logic                active_q;
    logic                done_q;
    logic [7:0]          cool_q;

    logic                frame_tick;
    logic                fire_qual;
    logic                hit_edge;
    logic [10:0]         x_ext;
    logic [10:0]         y_ext;

    frame_tick_sync u_sync (
        .clk_i   (Clk),
        .rst_ni  (Reset_n),
        .async_i (frame_clk),
        .tick_o  (frame_tick)
    );

`ifdef BULLET_AUTOFIRE_EN
    assign fire_qual = fire;
`else
    logic fire_prev_q;

    // Fire level seen on the previous tick, for 0->1 qualification.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            fire_prev_q <= 1'b0;
        end else if (frame_tick) begin
            fire_prev_q <= fire;
        end
    end

    assign fire_qual = fire & ~fire_prev_q;
`endif

    // Edge test in 11 bits so additions near the limit cannot wrap, plus the stepped position.
    always_comb begin
        x_ext      = {1'b0, bullet_x_q};
        y_ext      = {1'b0, bullet_y_q};
        hit_edge   = 1'b0;
        bullet_x_d = bullet_x_q;
        bullet_y_d = bullet_y_q;
        case (dir_q)
            DIR_UP: begin
                hit_edge   = y_ext < EDGE_SPAN;
                bullet_y_d = bullet_y_q - STEP;
            end
            DIR_DOWN: begin
                hit_edge   = (y_ext + EDGE_SPAN) > Y_LIMIT;
                bullet_y_d = bullet_y_q + STEP;
            end
            DIR_LEFT: begin
                hit_edge   = x_ext < EDGE_SPAN;
                bullet_x_d = bullet_x_q - STEP;
            end
            DIR_RIGHT: begin
                hit_edge   = (x_ext + EDGE_SPAN) > X_LIMIT;
                bullet_x_d = bullet_x_q + STEP;
            end
        endcase
    end

    // Shot state machine with registered outputs; acts only on frame ticks.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            dir_q      <= DIR_UP;
            cause_q    <= CAUSE_NONE;
            bullet_x_q <= '0;
            bullet_y_q <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            cool_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (frame_tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (fire_qual) begin
                            bullet_x_q <= BallX;
                            bullet_y_q <= BallY;
                            dir_q      <= dir_e'(direction);
                            cause_q    <= CAUSE_NONE;
                            active_q   <= 1'b1;
                            state_q    <= ST_FLIGHT;
                        end
                    end
                    ST_FLIGHT: begin
                        if (bullet_collision || hit_edge) begin
                            if (bullet_collision) begin
                                cause_q <= CAUSE_BARRIER;
                            end else begin
                                cause_q <= CAUSE_EDGE;
                            end
                            done_q   <= 1'b1;
                            active_q <= 1'b0;
                            cool_q   <= CD_LOAD;
                            state_q  <= ST_COOLDOWN;
                        end else begin
                            bullet_x_q <= bullet_x_d;
                            bullet_y_q <= bullet_y_d;
                        end
                    end
                    ST_COOLDOWN: begin
                        cool_q <= cool_q - 8'd1;
                        if (cool_q == 8'd1) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign BulletX       = bullet_x_q;
    assign BulletY       = bullet_y_q;
    assign Bullet_Size   = COORD_W'(BULLET_SIZE);
    assign bullet_active = active_q;
    assign shot_done     = done_q;
    assign despawn_cause = cause_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Self-checking bench for bullet_controller: a behavioural model predicts the
// outputs after each frame tick; predictions are queued and compared when the
// DUT has updated.
`timescale 1ns/1ps
module tb_bullet_controller;

    localparam int XMAX = 639;
    localparam int YMAX = 479;
    localparam int STEP = 4;
    localparam int SIZE = 2;
    localparam int CD   = 8;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       frame_clk = 1'b0;
    logic       fire = 1'b0;
    logic [1:0] direction = 2'b00;
    logic [9:0] BallX = '0;
    logic [9:0] BallY = '0;
    logic       bullet_collision = 1'b0;
    logic [9:0] BulletX;
    logic [9:0] BulletY;
    logic [9:0] Bullet_Size;
    logic       bullet_active;
    logic       shot_done;
    logic [1:0] despawn_cause;

    bullet_controller #(
        .SCREEN_X_MAX    (XMAX),
        .SCREEN_Y_MAX    (YMAX),
        .BULLET_STEP     (STEP),
        .BULLET_SIZE     (SIZE),
        .COOLDOWN_FRAMES (CD)
    ) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .frame_clk        (frame_clk),
        .fire             (fire),
        .direction        (direction),
        .BallX            (BallX),
        .BallY            (BallY),
        .bullet_collision (bullet_collision),
        .BulletX          (BulletX),
        .BulletY          (BulletY),
        .Bullet_Size      (Bullet_Size),
        .bullet_active    (bullet_active),
        .shot_done        (shot_done),
        .despawn_cause    (despawn_cause)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       active;
        logic       done;
        logic [1:0] cause;
    } exp_t;

    exp_t sb_q[$];

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // model state: 0 idle, 1 flight, 2 cooldown
    int   m_state = 0;
    int   m_x = 0;
    int   m_y = 0;
    int   m_dir = 0;
    int   m_cause = 0;
    int   m_cnt = 0;
    logic m_fire_prev = 1'b0;
    logic m_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_x = 0; m_y = 0; m_dir = 0; m_cause = 0; m_cnt = 0;
        m_fire_prev = 1'b0; m_done = 1'b0;
    endtask

    task automatic model_tick(input logic f, input logic c);
        logic qual;
        logic edge_hit;
`ifdef BULLET_AUTOFIRE_EN
        qual = f;
`else
        qual = f & ~m_fire_prev;
`endif
        m_fire_prev = f;
        m_done = 1'b0;
        case (m_state)
            0: if (qual) begin
                m_x = int'(BallX); m_y = int'(BallY); m_dir = int'(direction);
                m_cause = 0; m_state = 1;
            end
            1: begin
                case (m_dir)
                    0: edge_hit = m_y < STEP + SIZE;
                    1: edge_hit = m_y + STEP + SIZE > YMAX;
                    2: edge_hit = m_x < STEP + SIZE;
                    default: edge_hit = m_x + STEP + SIZE > XMAX;
                endcase
                if (c || edge_hit) begin
                    m_cause = c ? 1 : 2;
                    m_done = 1'b1; m_cnt = CD; m_state = 2;
                end else begin
                    case (m_dir)
                        0: m_y = m_y - STEP;
                        1: m_y = m_y + STEP;
                        2: m_x = m_x - STEP;
                        default: m_x = m_x + STEP;
                    endcase
                end
            end
            default: begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_state = 0;
            end
        endcase
    endtask

    // Called just after a posedge; returns just after a posedge.
    task automatic do_tick(input logic f, input logic c, input bit chk_tick);
        exp_t e;
        fire = f;
        bullet_collision = c;
        model_tick(f, c);
        e.x = 10'(m_x); e.y = 10'(m_y); e.active = (m_state == 1);
        e.done = m_done; e.cause = 2'(m_cause);
        sb_q.push_back(e);
        frame_clk = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(posedge Clk); #1;
            if (chk_tick) check("tick_timing", 32'(dut.frame_tick), 32'(i == 3));
        end
        e = sb_q.pop_front();
        check("BulletX", 32'(BulletX), 32'(e.x));
        check("BulletY", 32'(BulletY), 32'(e.y));
        check("bullet_active", 32'(bullet_active), 32'(e.active));
        check("shot_done", 32'(shot_done), 32'(e.done));
        check("despawn_cause", 32'(despawn_cause), 32'(e.cause));
        @(posedge Clk); #1;
        check("shot_done_width", 32'(shot_done), 32'd0);
        if (chk_tick) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge Clk); #1;
                check("tick_held_high", 32'(dut.frame_tick), 32'd0);
            end
        end
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic settle_idle();
        for (int n = 0; n < 200 && m_state != 0; n++) do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_shot(input int x, input int y, input int d);
        BallX = 10'(x); BallY = 10'(y); direction = 2'(d);
        do_tick(1'b1, 1'b0, 1'b0);
        for (int n = 0; n < 200 && m_state == 1; n++) do_tick(1'b0, 1'b0, 1'b0);
        settle_idle();
    endtask

    initial begin
        // reset
        repeat (3) @(posedge Clk);
        #1;
        check("rst_BulletX", 32'(BulletX), 32'd0);
        check("rst_BulletY", 32'(BulletY), 32'd0);
        check("rst_active", 32'(bullet_active), 32'd0);
        check("rst_done", 32'(shot_done), 32'd0);
        check("rst_cause", 32'(despawn_cause), 32'd0);
        check("Bullet_Size", 32'(Bullet_Size), 32'd2);
        Reset_n = 1'b1;
        model_reset();
        @(posedge Clk); #1;

        // tick timing from frame_clk rising edge, no repeat while held high
        do_tick(1'b0, 1'b0, 1'b1);

        // upward shot to the top edge; ball/direction changes mid-flight ignored
        BallX = 10'd160; BallY = 10'd80; direction = 2'b00;
        do_tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 19; k++) begin
            if (k == 5) begin
                BallX = 10'd300; BallY = 10'd300; direction = 2'b11;
            end
            do_tick(1'b0, 1'b0, 1'b0);
        end
        check("up_final_y", 32'(BulletY), 32'd4);
        check("up_final_x", 32'(BulletX), 32'd160);
        do_tick(1'b0, 1'b0, 1'b0);
        check("up_edge_cause", 32'(despawn_cause), 32'd2);
        settle_idle();

        // collision and edge on the same tick: collision wins
        BallX = 10'd160; BallY = 10'd80; direction = 2'b00;
        do_tick(1'b1, 1'b0, 1'b0);
        for (int k = 1; k <= 19; k++) do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1, 1'b0);
        check("both_cause", 32'(despawn_cause), 32'd1);
        check("both_y", 32'(BulletY), 32'd4);
        settle_idle();

        // rightward shot, collision on 3rd flight tick, fire held throughout
        BallX = 10'd160; BallY = 10'd240; direction = 2'b11;
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b1, 1'b0);
        check("coll_x", 32'(BulletX), 32'd168);
        check("coll_cause", 32'(despawn_cause), 32'd1);
        for (int k = 0; k < CD; k++) do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);
`ifdef BULLET_AUTOFIRE_EN
        check("held_fire_reshot", 32'(bullet_active), 32'd1);
`else
        check("held_fire_reshot", 32'(bullet_active), 32'd0);
`endif
        settle_idle();

        // fire edge on the last cooldown tick is ignored; next IDLE tick accepts
        BallX = 10'd320; BallY = 10'd240; direction = 2'b10;
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b1, 1'b0);
        for (int k = 1; k < CD; k++) do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);
        check("cooldown_fire_ignored", 32'(bullet_active), 32'd0);
        do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b1, 1'b0, 1'b0);
        check("fire_after_cooldown", 32'(bullet_active), 32'd1);
        do_tick(1'b0, 1'b1, 1'b0);
        settle_idle();

        // edge boundaries on the other sides
        run_shot(100, 470, 1);
        run_shot(7, 100, 2);
        run_shot(632, 50, 3);
        run_shot(320, 6, 0);

        // reset mid-flight aborts without shot_done
        BallX = 10'd200; BallY = 10'd200; direction = 2'b01;
        do_tick(1'b1, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        do_tick(1'b0, 1'b0, 1'b0);
        Reset_n = 1'b0;
        @(posedge Clk); #1;
        Reset_n = 1'b1;
        model_reset();
        check("midrst_active", 32'(bullet_active), 32'd0);
        check("midrst_x", 32'(BulletX), 32'd0);
        check("midrst_y", 32'(BulletY), 32'd0);
        check("midrst_cause", 32'(despawn_cause), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(posedge Clk); #1;
            check("midrst_no_done", 32'(shot_done), 32'd0);
        end
        do_tick(1'b0, 1'b0, 1'b0);
        run_shot(50, 50, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
